// File: rtl/opb_regbank_pkg.sv
// Shared types and helpers for the OPB software register bank.
package opb_regbank_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } opb_state_e;

  localparam int unsigned REG_STRIDE = 4;
  localparam int unsigned MAX_REGS   = 16;
  localparam int unsigned IDX_W      = 4;

  function automatic logic [31:0] reg_index(input logic [31:0] addr, input logic [31:0] base);
    return (addr - base) / REG_STRIDE;
  endfunction

  // be uses OPB ordering: be[0] is the most significant byte lane.
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [0:3]  be);
    logic [31:0] r;
    r = old_val;
    for (int unsigned k = 0; k < 4; k++) begin
      if (be[k]) r[31-8*k -: 8] = new_val[31-8*k -: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/opb_reg_slot.sv
// One 32-bit control register with byte-lane merge and a one-cycle write strobe.
module opb_reg_slot
  import opb_regbank_pkg::*;
#(
  parameter logic [31:0] RESET_VALUE = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [0:3]  be,
  input  logic [31:0] wdata,
  output logic [31:0] q,
  output logic        strobe
);

  logic [31:0] val_d, val_q;
  logic        strobe_d, strobe_q;

  always_comb begin
    val_d    = val_q;
    strobe_d = wr_en;
    if (wr_en) val_d = be_merge(val_q, wdata, be);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q    <= RESET_VALUE;
      strobe_q <= 1'b0;
    end else begin
      val_q    <= val_d;
      strobe_q <= strobe_d;
    end
  end

  assign q      = val_q;
  assign strobe = strobe_q;

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave exposing C_NUM_REGS control/status words in one address window.
module opb_register_bank_ppc2simulink
  import opb_regbank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR    = 32'h01060A00,
  parameter logic [31:0] C_HIGHADDR    = 32'h01060AFF,
  parameter int unsigned C_OPB_AWIDTH  = 32,
  parameter int unsigned C_OPB_DWIDTH  = 32,
  parameter int unsigned C_NUM_REGS    = 4,
  parameter logic [15:0] C_RO_MASK     = '0,
  parameter logic [31:0] C_RESET_VALUE = '0,
  parameter              C_FAMILY      = "virtex5"
) (
  input  logic                       OPB_Clk,
  input  logic                       OPB_Rst,
  input  logic [0:31]                OPB_ABus,
  input  logic [0:3]                 OPB_BE,
  input  logic [0:31]                OPB_DBus,
  input  logic                       OPB_RNW,
  input  logic                       OPB_select,
  input  logic                       OPB_seqAddr,
  output logic [0:31]                Sl_DBus,
  output logic                       Sl_xferAck,
  output logic                       Sl_errAck,
  output logic                       Sl_retry,
  output logic                       Sl_toutSup,
  output logic [C_NUM_REGS*32-1:0]   user_data_out,
  input  logic [C_NUM_REGS*32-1:0]   user_data_in,
  output logic [C_NUM_REGS-1:0]      user_wr_strobe
);

  localparam logic [32:0] WINDOW_BYTES = {1'b0, C_HIGHADDR} - {1'b0, C_BASEADDR} + 33'd1;

  if (C_NUM_REGS < 1 || C_NUM_REGS > MAX_REGS) begin : g_bad_count
    $error("C_NUM_REGS must be within 1..16");
  end
  if (33'(C_NUM_REGS * REG_STRIDE) > WINDOW_BYTES) begin : g_bad_window
    $error("address window too small for C_NUM_REGS registers");
  end
  if (C_OPB_AWIDTH != 32 || C_OPB_DWIDTH != 32) begin : g_bad_width
    $error("only 32-bit OPB address and data widths are supported");
  end

  opb_state_e         state_d, state_q;
  logic [31:0]        rd_d, rd_q, rd_mux;
  logic [31:0]        wdata_d, wdata_q;
  logic [0:3]         be_d, be_q;
  logic [IDX_W-1:0]   idx_d, idx_q;
  logic               wr_pend_d, wr_pend_q;
  logic [31:0]        addr, idx;
  logic               hit, in_range;
  logic [31:0]        reg_val [C_NUM_REGS];

  assign addr     = OPB_ABus;
  assign hit      = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign idx      = reg_index(addr, C_BASEADDR);
  assign in_range = idx < C_NUM_REGS;

  // Status words come straight from the fabric; control words from the slots.
  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
      if (idx == i) rd_mux = C_RO_MASK[i] ? user_data_in[32*i +: 32] : reg_val[i];
    end
  end

  always_comb begin
    state_d   = IDLE;
    rd_d      = '0;
    wr_pend_d = 1'b0;
    idx_d     = idx_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    if (state_q == IDLE && hit) begin
      state_d   = ACK;
      idx_d     = idx[IDX_W-1:0];
      be_d      = OPB_BE;
      wdata_d   = OPB_DBus;
      wr_pend_d = !OPB_RNW && in_range && !C_RO_MASK[idx[IDX_W-1:0]];
      if (OPB_RNW && in_range) rd_d = rd_mux;
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_q   <= IDLE;
      rd_q      <= '0;
      wr_pend_q <= 1'b0;
      idx_q     <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      wr_pend_q <= wr_pend_d;
      idx_q     <= idx_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
    end
  end

  for (genvar gi = 0; gi < C_NUM_REGS; gi++) begin : g_reg
    if (C_RO_MASK[gi]) begin : g_ro
      assign reg_val[gi]        = '0;
      assign user_wr_strobe[gi] = 1'b0;
    end else begin : g_ctl
      opb_reg_slot #(
        .RESET_VALUE(C_RESET_VALUE)
      ) u_slot (
        .clk   (OPB_Clk),
        .rst   (OPB_Rst),
        .wr_en (wr_pend_q && (idx_q == IDX_W'(gi))),
        .be    (be_q),
        .wdata (wdata_q),
        .q     (reg_val[gi]),
        .strobe(user_wr_strobe[gi])
      );
    end
    assign user_data_out[32*gi +: 32] = reg_val[gi];
  end

  assign Sl_xferAck = (state_q == ACK);
  assign Sl_DBus    = Sl_xferAck ? rd_q : '0;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{OPB_seqAddr, user_data_in, C_FAMILY};

endmodule

// File: doc/opb_register_bank_ppc2simulink.md
Name: opb_register_bank_ppc2simulink

Overview:
Parametrised OPB slave holding C_NUM_REGS 32-bit software registers in one address window. It replaces the one-register-per-core scheme for control banks such as the EQ coefficient controls. Each register is either control (PPC writes, fabric reads) or status (fabric drives, PPC reads). Writes support byte enables and raise a per-register update strobe. Everything runs on the OPB clock, so no clock-domain crossing logic is needed.

Parameters:
C_BASEADDR, 32'h01060A00, first byte address of window
C_HIGHADDR, 32'h01060AFF, last byte address of window
C_OPB_AWIDTH, 32, OPB address width (only 32 supported)
C_OPB_DWIDTH, 32, OPB data width (only 32 supported)
C_NUM_REGS, 4, register count, 1..16, word stride 4 bytes
C_RO_MASK, 0 (16 bits), bit i=1 makes register i status/read-only
C_RESET_VALUE, 32'h00000000, reset value of every control register
C_FAMILY, "virtex5", target family (informational)

Ports:
OPB_Clk  in  1  sole clock
OPB_Rst  in  1  synchronous active-high reset
OPB_ABus  in  [0:31]  byte address
OPB_BE  in  [0:3]  byte enables; BE[0] covers DBus[0:7]
OPB_DBus  in  [0:31]  write data
OPB_RNW  in  1  1=read, 0=write
OPB_select  in  1  transfer request
OPB_seqAddr  in  1  sequential hint; ignored
Sl_DBus  out  [0:31]  read data; zero except during ack
Sl_xferAck  out  1  transfer acknowledge
Sl_errAck  out  1  tied 0
Sl_retry  out  1  tied 0
Sl_toutSup  out  1  tied 0
user_data_out  out  [C_NUM_REGS*32-1:0]  register i at bits [32i+31:32i]
user_data_in  in  [C_NUM_REGS*32-1:0]  status sources, same packing
user_wr_strobe  out  [C_NUM_REGS-1:0]  one-cycle pulse per accepted write

Behaviour:
- Bit mapping: OPB bit 0 = user bit 31. BE[k] governs user bits [31-8k:24-8k].
- Hit: OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR. Index = (OPB_ABus - C_BASEADDR) >> 2.
- FSM states:
  - IDLE: on hit, go to ACK.
  - ACK: Sl_xferAck=1 for exactly this cycle; always return to IDLE.
  - Minimum transfer period is 2 cycles. The slave never acks twice in a row.
- Latency: hit sampled at cycle n; Sl_xferAck and Sl_DBus valid at cycle n+1.
- Read data path:
  - Index < C_NUM_REGS, RO bit set: registered user_data_in slice, sampled at cycle n.
  - Index < C_NUM_REGS, RO bit clear: current register value.
  - Index >= C_NUM_REGS: 0.
  - Sl_DBus=0 whenever Sl_xferAck=0 (OPB wired-OR requirement).
- Write (RNW=0), control register:
  - Enabled bytes are updated at the end of the ACK cycle; disabled bytes are retained.
  - New value appears on user_data_out at n+2.
  - user_wr_strobe[i]=1 at n+2 for one cycle, including when BE=0000.
- Write to an RO register or an out-of-range index: acked, no state change, no strobe.
- Address outside the window: no ack, Sl_DBus stays 0 (bus timeout is the master's concern).
- RO register slices of user_data_out are driven 0.
- OPB_select dropping during ACK: ack still completes, since the capture was already made.
- Reset: applies in any state and takes effect at the next edge.
  - FSM returns to IDLE.
  - Control registers load C_RESET_VALUE; strobes and Sl_* go to 0.
  - A transfer in ACK at reset is abandoned: no ack, no write.
- Elaboration error if C_NUM_REGS*4 > C_HIGHADDR-C_BASEADDR+1, or if C_NUM_REGS is outside 1..16.

Decomposition:
- Package opb_regbank_pkg:
  - FSM state enum {IDLE, ACK}
  - REG_STRIDE=4, MAX_REGS=16
  - Function reg_index(addr, base)
  - Function be_merge(old, new, be), which does the big-endian byte-lane mapping
- Sub-module opb_reg_slot: one 32-bit register with byte-enable merge, reset value and strobe. Instantiated per control register by generate.

Test Plan:
- Reset (defaults: 4 regs, C_RO_MASK=4'b1000) -> all user_data_out=0, Sl_DBus=0, Sl_xferAck=0, strobes=0.
- Write 0xDEADBEEF to 0x01060A04, BE=1111 -> ack at n+1 only; reg1=0xDEADBEEF and user_wr_strobe=0010 at n+2; then read 0x01060A04 -> Sl_DBus=0xDEADBEEF in the ack cycle, 0 otherwise.
- Write 0x00AA0000 to reg1, BE=0100 -> reg1=0xDEAABEEF; strobe[1] pulses once.
- user_data_in[127:96]=0x12345678, read 0x01060A0C -> Sl_DBus=0x12345678; write 0xFFFFFFFF there -> acked, no strobe, read still 0x12345678.
- Read 0x01060A40 -> ack, Sl_DBus=0; write there -> no register or strobe change. Access 0x01060B00 -> no ack for 20 cycles.
- OPB_Rst asserted during the ACK cycle of a write of 0x55 to reg0 -> no ack next cycle, reg0=0, strobe stays 0. Hold select 6 cycles with a valid address -> exactly 3 acks, on alternating cycles.
